// File: rtl/twiddle_pkg.sv
// Shared constants, types and helpers for the R2^2 twiddle generator.
// TWIDDLE_GEN_OUT_REG_EN adds one output register stage (PL = 3).
package twiddle_pkg;

`ifdef TWIDDLE_GEN_OUT_REG_EN
    localparam int unsigned PL = 3;
`else
    localparam int unsigned PL = 2;
`endif

    // Outputs carry one bit above TW_BW so that +/-1.0 are both representable
    localparam int unsigned TW_SIGN_BITS = 1;

    // R2^2 multiplier for quarter q of the index space
    localparam logic [1:0] R22_MAP [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } tw_state_e;

    function automatic int unsigned skew_start(input int unsigned skew,
                                               input int unsigned log2n);
        int unsigned n;
        n = 32'd1 << log2n;
        return (n - (skew % n)) % n;
    endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Control/data bundle between an FFT stage controller and twiddle_gen.
interface twiddle_gen_if #(
    parameter int unsigned LEN_BW = 4,
    parameter int unsigned TW_BW  = 16
);
    logic                     start;
    logic                     stop;
    logic [LEN_BW-1:0]        cfg_log2len;
    logic                     cfg_inverse;
    logic                     busy;
    logic signed [TW_BW:0]    tw_r;
    logic signed [TW_BW:0]    tw_i;
    logic                     tw_valid;

    modport master (
        output start, stop, cfg_log2len, cfg_inverse,
        input  busy, tw_r, tw_i, tw_valid
    );

    modport slave (
        input  start, stop, cfg_log2len, cfg_inverse,
        output busy, tw_r, tw_i, tw_valid
    );
endinterface

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM, depth 2^(MAX_LOG2-2)+1, two registered read ports.
// Contents are computed at elaboration: C[j] = round(cos(2*pi*j/2^MAX_LOG2) * 2^(TW_BW-1)).
module twiddle_qrom #(
    parameter int unsigned MAX_LOG2 = 10,
    parameter int unsigned TW_BW    = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_nrst,
    input  logic                      i_en,
    input  logic [MAX_LOG2-2:0]       i_addr_a,
    input  logic [MAX_LOG2-2:0]       i_addr_b,
    output logic signed [TW_BW:0]     o_data_a,
    output logic signed [TW_BW:0]     o_data_b
);

    localparam int unsigned Q     = 1 << (MAX_LOG2 - 2);
    localparam int unsigned DEPTH = Q + 1;
    localparam real         TWO_PI = 6.283185307179586;

    logic signed [TW_BW:0] w_rom [DEPTH];

    // First-quadrant cosine is non-negative, so +0.5 then truncate rounds to nearest
    for (genvar j = 0; j < DEPTH; j++) begin : g_rom
        localparam real ANG = TWO_PI * j / (2.0 ** MAX_LOG2);
        localparam int  VAL = $rtoi($cos(ANG) * (2.0 ** (TW_BW - 1)) + 0.5);
        assign w_rom[j] = (TW_BW+1)'(VAL);
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            o_data_a <= '0;
            o_data_b <= '0;
        end else if (i_en) begin
            o_data_a <= w_rom[i_addr_a];
            o_data_b <= w_rom[i_addr_b];
        end
    end

endmodule

// File: rtl/twiddle_gen.sv
// ROM-based twiddle generator for one radix-2^2 SDF stage: emits W_N^(n*m) in R2^2 order.
// Optional macro TWIDDLE_GEN_OUT_REG_EN adds an output register (latency 3 instead of 2).
module twiddle_gen
    import twiddle_pkg::*;
#(
    parameter int unsigned MAX_LOG2  = 10,
    parameter int unsigned TW_BW     = 16,
    parameter int unsigned INIT_SKEW = 0,
    parameter int unsigned LEN_BW    = 4
) (
    input  logic          sys_clk,
    input  logic          sys_nrst,
    input  logic          sys_en,
    twiddle_gen_if.slave  bus
);

    localparam int unsigned AW    = MAX_LOG2;
    localparam int unsigned AA    = MAX_LOG2 - 1;
    localparam int unsigned OUT_W = TW_BW + TW_SIGN_BITS;
    localparam int unsigned Q     = 1 << (MAX_LOG2 - 2);

    tw_state_e          r_state;
    tw_state_e          w_state_nxt;
    logic [1:0]         r_fill_cnt;
    logic [1:0]         w_fill_cnt_nxt;
    logic               w_start_acc;
    logic               w_keep;

    logic [LEN_BW-1:0]  r_len;
    logic [LEN_BW-1:0]  w_len_clamp;
    logic               r_inv;

    logic [AW-1:0]      r_k;
    logic [AW-1:0]      w_k_nxt;
    logic [AW-1:0]      w_k_start;
    logic [AW:0]        w_nsize;
    logic [AW:0]        w_quarter;
    logic [AW-1:0]      w_kmask;
    logic [AW-1:0]      w_nmask;
    logic [AW-1:0]      w_n;
    logic [AW-1:0]      w_e;
    logic [1:0]         w_q;
    logic [1:0]         w_m;
    logic [1:0]         w_reg;
    logic [LEN_BW-1:0]  w_qshift;
    logic [LEN_BW-1:0]  w_ashift;
    logic [AA-1:0]      w_addr_a;
    logic [AA-1:0]      w_addr_b;

    logic               r_v1;
    logic [1:0]         r_reg1;
    logic signed [OUT_W-1:0] w_rom_a;
    logic signed [OUT_W-1:0] w_rom_b;
    logic signed [OUT_W-1:0] w_cos;
    logic signed [OUT_W-1:0] w_sin;
    logic signed [OUT_W-1:0] w_im;
    logic signed [OUT_W-1:0] r_tw_r;
    logic signed [OUT_W-1:0] r_tw_i;

    always_comb begin
        w_len_clamp = bus.cfg_log2len;
        if (bus.cfg_log2len < LEN_BW'(2)) begin
            w_len_clamp = LEN_BW'(2);
        end else if (bus.cfg_log2len > LEN_BW'(MAX_LOG2)) begin
            w_len_clamp = LEN_BW'(MAX_LOG2);
        end
    end

    assign w_k_start = AW'(skew_start(INIT_SKEW, 32'(w_len_clamp)));

    always_comb begin
        w_state_nxt    = r_state;
        w_fill_cnt_nxt = r_fill_cnt;
        w_start_acc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_start_acc    = 1'b1;
                    w_state_nxt    = ST_FILL;
                    w_fill_cnt_nxt = '0;
                end
            end
            ST_FILL: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_fill_cnt == 2'(PL - 1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fill_cnt_nxt = r_fill_cnt + 2'd1;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Pipeline stages only advance while the run continues past this edge; a stop discards them
    assign w_keep = (r_state != ST_IDLE) && (w_state_nxt != ST_IDLE);

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            r_state    <= ST_IDLE;
            r_fill_cnt <= '0;
            r_len      <= LEN_BW'(MAX_LOG2);
            r_inv      <= 1'b0;
            r_k        <= '0;
        end else if (sys_en) begin
            r_state    <= w_state_nxt;
            r_fill_cnt <= w_fill_cnt_nxt;
            if (w_start_acc) begin
                r_len <= w_len_clamp;
                r_inv <= bus.cfg_inverse;
                r_k   <= w_k_start;
            end else if (r_state != ST_IDLE) begin
                r_k   <= w_k_nxt;
            end
        end
    end

    always_comb begin
        w_nsize   = (AW+1)'(1) << r_len;
        w_kmask   = AW'(w_nsize - (AW+1)'(1));
        w_k_nxt   = (r_k + AW'(1)) & w_kmask;
        w_qshift  = r_len - LEN_BW'(2);
        w_quarter = (AW+1)'(1) << w_qshift;
        w_nmask   = AW'(w_quarter - (AW+1)'(1));
        w_n       = r_k & w_nmask;
        w_q       = 2'(r_k >> w_qshift);
        w_m       = R22_MAP[w_q];
        w_e       = w_n * AW'(w_m);
        w_reg     = 2'(w_e >> w_qshift);
        w_ashift  = LEN_BW'(MAX_LOG2) - r_len;
        w_addr_a  = AA'((w_e & w_nmask) << w_ashift);
        w_addr_b  = AA'(Q) - w_addr_a;
    end

    twiddle_qrom #(
        .MAX_LOG2 (MAX_LOG2),
        .TW_BW    (TW_BW)
    ) u_qrom (
        .sys_clk  (sys_clk),
        .sys_nrst (sys_nrst),
        .i_en     (sys_en),
        .i_addr_a (w_addr_a),
        .i_addr_b (w_addr_b),
        .o_data_a (w_rom_a),
        .o_data_b (w_rom_b)
    );

    always_comb begin
        w_cos = w_rom_a;
        w_sin = w_rom_b;
        case (r_reg1)
            2'd1: begin
                w_cos = -w_rom_b;
                w_sin = w_rom_a;
            end
            2'd2: begin
                w_cos = -w_rom_a;
                w_sin = -w_rom_b;
            end
            default: ;
        endcase
        w_im = r_inv ? w_sin : -w_sin;
    end

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            r_v1   <= 1'b0;
            r_reg1 <= '0;
            r_tw_r <= '0;
            r_tw_i <= '0;
        end else if (sys_en) begin
            r_v1   <= w_keep;
            r_reg1 <= w_reg;
            if (r_v1 && w_keep) begin
                r_tw_r <= w_cos;
                r_tw_i <= w_im;
            end
        end
    end

`ifdef TWIDDLE_GEN_OUT_REG_EN
    logic                    r_v2;
    logic signed [OUT_W-1:0] r_out_r;
    logic signed [OUT_W-1:0] r_out_i;

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            r_v2    <= 1'b0;
            r_out_r <= '0;
            r_out_i <= '0;
        end else if (sys_en) begin
            r_v2 <= r_v1 && w_keep;
            if (r_v2 && w_keep) begin
                r_out_r <= r_tw_r;
                r_out_i <= r_tw_i;
            end
        end
    end

    assign bus.tw_r = r_out_r;
    assign bus.tw_i = r_out_i;
`else
    assign bus.tw_r = r_tw_r;
    assign bus.tw_i = r_tw_i;
`endif

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.tw_valid = (r_state == ST_RUN);

endmodule
